fetch_unit: RTL



---
 rtl/fetch_unit_if.sv | 27 ++
 rtl/fetch_unit.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory req/gnt/rvalid port, redirect input
// and the valid/ready handoff toward decode.
interface fetch_unit_if;
   logic        imem_req_o;
   logic [31:0] imem_addr_o;
   logic        imem_gnt_i;
   logic        imem_rvalid_i;
   logic [31:0] imem_rdata_i;
   logic        redirect_i;
   logic [31:0] redirect_pc_i;
   logic        instr_valid_o;
   logic [31:0] instr_o;
   logic [31:0] pc_o;
   logic        instr_ready_i;

   modport master (
      output imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
      input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
      input  instr_ready_i
   );

   modport slave (
      input  imem_req_o, imem_addr_o, instr_valid_o, instr_o, pc_o,
      output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
      output instr_ready_i
   );
endinterface

// File: rtl/fetch_unit.sv
// RV32I instruction fetch stage: PC generation, request throttling, prefetch FIFO
// and redirect flush with discard of in-flight responses.
module fetch_unit_checker #(
   parameter int CW         = 3,
   parameter int FIFO_DEPTH = 4
) (
   input logic          clk_i,
   input logic          res_i,
   input logic          req,
   input logic          gnt,
   input logic          redirect,
   input logic [31:0]   addr,
   input logic          valid,
   input logic [CW-1:0] count,
   input logic [CW-1:0] outst,
   input logic [CW-1:0] discard
);
   ap_addr_align : assert property (@(posedge clk_i) disable iff (!res_i)
      addr[1:0] == 2'b00);
   ap_slot_bound : assert property (@(posedge clk_i) disable iff (!res_i)
      ({1'b0, count} + {1'b0, outst}) <= (CW + 1)'(FIFO_DEPTH));
   ap_discard_le : assert property (@(posedge clk_i) disable iff (!res_i)
      discard <= outst);
   ap_valid_cnt  : assert property (@(posedge clk_i) disable iff (!res_i)
      valid == (count != {CW{1'b0}}));
   ap_addr_hold  : assert property (@(posedge clk_i) disable iff (!res_i)
      (req && !gnt && !redirect) |=> (addr == $past(addr)));
endmodule

module fetch_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4
) (
   input logic          clk_i,
   input logic          res_i,
   fetch_unit_if.master bus
);
   localparam int          PW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int          CW      = PW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

   logic [31:0]   fetch_pc_r, resp_pc_r;
   logic [CW-1:0] count_r, outst_r, discard_r;
   logic [PW-1:0] wr_ptr_r, rd_ptr_r;
   logic          req_r, valid_r;
   logic [31:0]   mem_pc_r    [FIFO_DEPTH];
   logic [31:0]   mem_instr_r [FIFO_DEPTH];

   logic          grant_s, resp_s, keep_s, pop_s, push_s;
   logic [31:0]   fetch_pc_nxt_s, resp_pc_nxt_s;
   logic [CW-1:0] count_nxt_s, outst_nxt_s, discard_nxt_s;
   logic [PW-1:0] wr_ptr_nxt_s, rd_ptr_nxt_s;
   logic          req_nxt_s, valid_nxt_s;

   // Next-state: grants, kept/dropped responses, pops, with redirect overriding all
   always_comb begin
      grant_s        = req_r & bus.imem_gnt_i;
      // an rvalid with nothing outstanding is a protocol error and is ignored
      resp_s         = bus.imem_rvalid_i & (outst_r != {CW{1'b0}});
      keep_s         = resp_s & (discard_r == {CW{1'b0}});
      pop_s          = valid_r & bus.instr_ready_i;
      outst_nxt_s    = outst_r + CW'(grant_s) - CW'(resp_s);
      fetch_pc_nxt_s = fetch_pc_r;
      resp_pc_nxt_s  = resp_pc_r;
      discard_nxt_s  = discard_r;
      count_nxt_s    = count_r;
      wr_ptr_nxt_s   = wr_ptr_r;
      rd_ptr_nxt_s   = rd_ptr_r;
      push_s         = 1'b0;
      if (pop_s) begin
         rd_ptr_nxt_s = rd_ptr_r + PW'(1);
      end else begin
         rd_ptr_nxt_s = rd_ptr_r;
      end
      if (bus.redirect_i) begin
         // discard covers every request still owed a response, including this cycle's grant
         fetch_pc_nxt_s = bus.redirect_pc_i & 32'hFFFF_FFFC;
         resp_pc_nxt_s  = bus.redirect_pc_i & 32'hFFFF_FFFC;
         discard_nxt_s  = outst_nxt_s;
         count_nxt_s    = {CW{1'b0}};
         wr_ptr_nxt_s   = {PW{1'b0}};
         rd_ptr_nxt_s   = {PW{1'b0}};
         push_s         = 1'b0;
      end else begin
         push_s = keep_s;
         if (grant_s) begin
            fetch_pc_nxt_s = fetch_pc_r + 32'd4;
         end else begin
            fetch_pc_nxt_s = fetch_pc_r;
         end
         if (keep_s) begin
            resp_pc_nxt_s = resp_pc_r + 32'd4;
            wr_ptr_nxt_s  = wr_ptr_r + PW'(1);
         end else begin
            resp_pc_nxt_s = resp_pc_r;
            wr_ptr_nxt_s  = wr_ptr_r;
         end
         if (resp_s && (discard_r != {CW{1'b0}})) begin
            discard_nxt_s = discard_r - CW'(1);
         end else begin
            discard_nxt_s = discard_r;
         end
         count_nxt_s = count_r + CW'(keep_s) - CW'(pop_s);
      end
      req_nxt_s   = ({1'b0, count_nxt_s} + {1'b0, outst_nxt_s}) < DEPTH_W;
      valid_nxt_s = (count_nxt_s != {CW{1'b0}});
   end

   // Control state and registered handshake outputs
   always_ff @(posedge clk_i or negedge res_i) begin
      if (!res_i) begin
         fetch_pc_r <= RESET_PC;
         resp_pc_r  <= RESET_PC;
         count_r    <= {CW{1'b0}};
         outst_r    <= {CW{1'b0}};
         discard_r  <= {CW{1'b0}};
         wr_ptr_r   <= {PW{1'b0}};
         rd_ptr_r   <= {PW{1'b0}};
         req_r      <= 1'b0;
         valid_r    <= 1'b0;
      end else begin
         fetch_pc_r <= fetch_pc_nxt_s;
         resp_pc_r  <= resp_pc_nxt_s;
         count_r    <= count_nxt_s;
         outst_r    <= outst_nxt_s;
         discard_r  <= discard_nxt_s;
         wr_ptr_r   <= wr_ptr_nxt_s;
         rd_ptr_r   <= rd_ptr_nxt_s;
         req_r      <= req_nxt_s;
         valid_r    <= valid_nxt_s;
      end
   end

   // Prefetch FIFO storage of {pc, instr}
   always_ff @(posedge clk_i or negedge res_i) begin
      if (!res_i) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_pc_r[i]    <= 32'h0000_0000;
            mem_instr_r[i] <= 32'h0000_0000;
         end
      end else begin
         if (push_s) begin
            mem_pc_r[wr_ptr_r]    <= resp_pc_r;
            mem_instr_r[wr_ptr_r] <= bus.imem_rdata_i;
         end else begin
            mem_pc_r[wr_ptr_r]    <= mem_pc_r[wr_ptr_r];
            mem_instr_r[wr_ptr_r] <= mem_instr_r[wr_ptr_r];
         end
      end
   end

   assign bus.imem_req_o    = req_r;
   assign bus.imem_addr_o   = fetch_pc_r;
   assign bus.instr_valid_o = valid_r;
   // head data is forced to zero whenever nothing is valid, including reset
   assign bus.instr_o       = valid_r ? mem_instr_r[rd_ptr_r] : 32'h0000_0000;
   assign bus.pc_o          = valid_r ? mem_pc_r[rd_ptr_r]    : 32'h0000_0000;

   fetch_unit_checker #(.CW(CW), .FIFO_DEPTH(FIFO_DEPTH)) u_chk (
      .clk_i    (clk_i),
      .res_i    (res_i),
      .req      (req_r),
      .gnt      (bus.imem_gnt_i),
      .redirect (bus.redirect_i),
      .addr     (fetch_pc_r),
      .valid    (valid_r),
      .count    (count_r),
      .outst    (outst_r),
      .discard  (discard_r)
   );
endmodule
